// File: rtl/drum_pkg.sv
`default_nettype none
// ============================================================================
// Package : drum_pkg
// Desc    : Shared node type and sweep FSM encoding for the drum column blocks.
// Rev     : 1.0
// ============================================================================
package drum_pkg;

   localparam int DATA_W = 18;

   typedef logic signed [DATA_W-1:0] node_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2,
      FIN   = 2'd3
   } sweep_state_t;

endpackage
`default_nettype wire

// File: rtl/drum_column_sweeper.sv
`default_nettype none
// ============================================================================
// Module : drum_column_sweeper
// Desc   : Streams one drum column row by row through an external node solver
//          and writes each result back in place (curr <- next, prev <- curr).
// Rev    : 1.0
// ============================================================================
module drum_column_sweeper #(
   parameter int N_ROWS    = 32,
   parameter int ADDR_W    = 5,
   parameter int DATA_W    = drum_pkg::DATA_W,
   parameter int PROBE_ROW = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     is_left_edge,
   input  logic                     is_right_edge,
   output logic                     busy,
   output logic                     done,
   output logic        [ADDR_W-1:0] rd_addr,
   input  logic signed [DATA_W-1:0] curr_rd_data,
   input  logic signed [DATA_W-1:0] prev_rd_data,
   input  logic signed [DATA_W-1:0] left_rd_data,
   input  logic signed [DATA_W-1:0] right_rd_data,
   output logic                     wr_en,
   output logic        [ADDR_W-1:0] wr_addr,
   output logic signed [DATA_W-1:0] curr_wr_data,
   output logic signed [DATA_W-1:0] prev_wr_data,
   output logic signed [DATA_W-1:0] sol_left,
   output logic signed [DATA_W-1:0] sol_right,
   output logic signed [DATA_W-1:0] sol_up,
   output logic signed [DATA_W-1:0] sol_down,
   output logic signed [DATA_W-1:0] sol_u,
   output logic signed [DATA_W-1:0] sol_uprev,
   input  logic signed [DATA_W-1:0] sol_next,
   output logic signed [DATA_W-1:0] probe_out
);
   import drum_pkg::*;

   localparam logic [ADDR_W-1:0] c_last_row  = ADDR_W'(N_ROWS - 1);
   localparam logic [ADDR_W-1:0] c_probe_row = ADDR_W'(PROBE_ROW);

   sweep_state_t              r_state;
   logic                      r_busy;
   logic                      r_done;
   logic                      r_wr_en;
   logic [ADDR_W-1:0]         r_row;
   logic [ADDR_W-1:0]         r_rd_addr;
   logic signed [DATA_W-1:0]  r_dn;
   logic signed [DATA_W-1:0]  r_cur;
   logic signed [DATA_W-1:0]  r_pv;
   logic signed [DATA_W-1:0]  r_lf;
   logic signed [DATA_W-1:0]  r_rt;
   logic signed [DATA_W-1:0]  r_probe;

   logic w_first_row;
   logic w_last_row;
   logic w_need_read;

   assign w_first_row = (r_row == '0);
   assign w_last_row  = (r_row == c_last_row);
   // rd_addr runs two rows ahead of the row being written
   assign w_need_read = (int'(r_row) + 3) < N_ROWS;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_wr_en   <= 1'b0;
         r_row     <= '0;
         r_rd_addr <= '0;
         r_dn      <= '0;
         r_cur     <= '0;
         r_pv      <= '0;
         r_lf      <= '0;
         r_rt      <= '0;
         r_probe   <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_busy    <= 1'b1;
                  r_rd_addr <= ADDR_W'(1);
                  r_state   <= PRIME;
               end
            end
            PRIME: begin
               r_dn      <= '0;
               r_cur     <= curr_rd_data;
               r_pv      <= prev_rd_data;
               r_lf      <= left_rd_data;
               r_rt      <= right_rd_data;
               r_row     <= '0;
               r_rd_addr <= ADDR_W'(2);
               r_wr_en   <= 1'b1;
               r_state   <= RUN;
            end
            RUN: begin
               r_dn  <= r_cur;
               r_cur <= curr_rd_data;
               r_pv  <= prev_rd_data;
               r_lf  <= left_rd_data;
               r_rt  <= right_rd_data;
               if (r_row == c_probe_row) begin
                  r_probe <= sol_next;
               end
               if (w_last_row) begin
                  r_wr_en   <= 1'b0;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
                  r_row     <= '0;
                  r_rd_addr <= '0;
                  r_state   <= FIN;
               end else begin
                  r_row <= r_row + ADDR_W'(1);
                  if (w_need_read) begin
                     r_rd_addr <= r_rd_addr + ADDR_W'(1);
                  end
               end
            end
            FIN: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // r_wr_en is high exactly during RUN, so it also gates the solver window
   assign sol_u     = r_wr_en ? r_cur : '0;
   assign sol_uprev = r_wr_en ? r_pv  : '0;
   assign sol_down  = (r_wr_en && !w_first_row)   ? r_dn         : '0;
   assign sol_up    = (r_wr_en && !w_last_row)    ? curr_rd_data : '0;
   assign sol_left  = (r_wr_en && !is_left_edge)  ? r_lf         : '0;
   assign sol_right = (r_wr_en && !is_right_edge) ? r_rt         : '0;

   assign curr_wr_data = sol_next;
   assign prev_wr_data = r_cur;
   assign wr_en        = r_wr_en;
   assign wr_addr      = r_row;
   assign rd_addr      = r_rd_addr;
   assign busy         = r_busy;
   assign done         = r_done;
   assign probe_out    = r_probe;

endmodule
`default_nettype wire

// File: tb/tb_drum_column_sweeper.sv
`default_nettype none
// ============================================================================
// Module : tb_drum_column_sweeper
// Desc   : Bench for drum_column_sweeper with RAM models and a summing solver.
// Rev    : 1.0
// ============================================================================
module tb_drum_column_sweeper;
   localparam int N     = 4;
   localparam int AW    = 3;
   localparam int DW    = 18;
   localparam int PROBE = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          is_left_edge = 1'b0;
   logic          is_right_edge = 1'b0;
   logic          busy, done, wr_en;
   logic [AW-1:0] rd_addr, wr_addr;
   logic [DW-1:0] curr_rd_data, prev_rd_data, left_rd_data, right_rd_data;
   logic [DW-1:0] curr_wr_data, prev_wr_data;
   logic [DW-1:0] sol_left, sol_right, sol_up, sol_down, sol_u, sol_uprev, sol_next;
   logic [DW-1:0] probe_out;

   int            n_checks = 0;
   int            n_fail = 0;
   logic [DW-1:0] exp_probe = '0;

   logic [DW-1:0] curr_mem [0:7];
   logic [DW-1:0] prev_mem [0:7];
   logic [DW-1:0] left_mem [0:7];
   logic [DW-1:0] right_mem [0:7];
   logic [DW-1:0] init_curr [0:7];
   logic [DW-1:0] init_prev [0:7];
   logic          load_req = 1'b0;

   always #5 clk = ~clk;

   assign sol_next = sol_up + sol_down + sol_left + sol_right;

   drum_column_sweeper #(
      .N_ROWS(N), .ADDR_W(AW), .DATA_W(DW), .PROBE_ROW(PROBE)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .is_left_edge(is_left_edge), .is_right_edge(is_right_edge),
      .busy(busy), .done(done), .rd_addr(rd_addr),
      .curr_rd_data(curr_rd_data), .prev_rd_data(prev_rd_data),
      .left_rd_data(left_rd_data), .right_rd_data(right_rd_data),
      .wr_en(wr_en), .wr_addr(wr_addr),
      .curr_wr_data(curr_wr_data), .prev_wr_data(prev_wr_data),
      .sol_left(sol_left), .sol_right(sol_right), .sol_up(sol_up),
      .sol_down(sol_down), .sol_u(sol_u), .sol_uprev(sol_uprev),
      .sol_next(sol_next), .probe_out(probe_out)
   );

   // Synchronous-read RAMs; own column is written back, neighbours are static
   always @(posedge clk) begin
      curr_rd_data  <= curr_mem[rd_addr];
      prev_rd_data  <= prev_mem[rd_addr];
      left_rd_data  <= left_mem[rd_addr];
      right_rd_data <= right_mem[rd_addr];
      if (load_req) begin
         for (int i = 0; i < 8; i++) begin
            curr_mem[i] <= init_curr[i];
            prev_mem[i] <= init_prev[i];
         end
      end else if (wr_en) begin
         curr_mem[wr_addr] <= curr_wr_data;
         prev_mem[wr_addr] <= prev_wr_data;
      end
   end

   task automatic do_load();
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic load_directed(input int c_base, input int lr);
      for (int i = 0; i < 8; i++) begin
         init_curr[i] = (i < N && c_base > 0) ? DW'(i + c_base) : '0;
         init_prev[i] = '0;
         left_mem[i]  = DW'(lr);
         right_mem[i] = DW'(lr);
      end
      do_load();
   endtask

   // Drives one sweep (start on cycle 0) and checks every cycle against a row-level model.
   task automatic run_sweep(input int restart_cyc, input int rst_cyc);
      logic [DW-1:0] c0 [N];
      logic [DW-1:0] p0 [N];
      logic [DW-1:0] e_up [N];
      logic [DW-1:0] e_dn [N];
      logic [DW-1:0] e_l [N];
      logic [DW-1:0] e_r [N];
      logic [DW-1:0] e_next [N];
      int   wr_cnt, done_cnt, r, exp_rd;
      logic aborted, exp_busy, exp_done, exp_wr;
      for (int i = 0; i < N; i++) begin
         c0[i] = curr_mem[i];
         p0[i] = prev_mem[i];
      end
      for (int i = 0; i < N; i++) begin
         e_up[i] = '0;
         e_dn[i] = '0;
         if (i < N - 1) e_up[i] = c0[i+1];
         if (i > 0)     e_dn[i] = c0[i-1];
         e_l[i]    = is_left_edge  ? '0 : left_mem[i];
         e_r[i]    = is_right_edge ? '0 : right_mem[i];
         e_next[i] = e_up[i] + e_dn[i] + e_l[i] + e_r[i];
      end
      wr_cnt = 0;
      done_cnt = 0;
      for (int cyc = 0; cyc < N + 4; cyc++) begin
         aborted = (rst_cyc >= 0) && (cyc > rst_cyc);
         if (aborted && cyc == rst_cyc + 1) exp_probe = '0;
         if (!aborted && cyc == PROBE + 3) exp_probe = e_next[PROBE];
         exp_busy = !aborted && cyc >= 1 && cyc <= N + 1;
         exp_done = !aborted && cyc == N + 2;
         exp_wr   = !aborted && cyc >= 2 && cyc <= N + 1;
         n_checks++;
         if (busy !== exp_busy) begin
            n_fail++; $display("FAIL busy cyc=%0d got=%0b exp=%0b", cyc, busy, exp_busy);
         end
         n_checks++;
         if (done !== exp_done) begin
            n_fail++; $display("FAIL done cyc=%0d got=%0b exp=%0b", cyc, done, exp_done);
         end
         n_checks++;
         if (wr_en !== exp_wr) begin
            n_fail++; $display("FAIL wr_en cyc=%0d got=%0b exp=%0b", cyc, wr_en, exp_wr);
         end
         n_checks++;
         if (probe_out !== exp_probe) begin
            n_fail++; $display("FAIL probe cyc=%0d got=%0d exp=%0d", cyc, probe_out, exp_probe);
         end
         if (cyc <= N + 1) begin
            exp_rd = aborted ? 0 : ((cyc < N) ? cyc : N - 1);
            n_checks++;
            if (rd_addr !== AW'(exp_rd)) begin
               n_fail++; $display("FAIL rd_addr cyc=%0d got=%0d exp=%0d", cyc, rd_addr, exp_rd);
            end
         end
         if (wr_en === 1'b1) wr_cnt++;
         if (done === 1'b1) done_cnt++;
         if (exp_wr) begin
            r = cyc - 2;
            n_checks++;
            if (wr_addr !== AW'(r)) begin
               n_fail++; $display("FAIL wr_addr row=%0d got=%0d exp=%0d", r, wr_addr, r);
            end
            n_checks++;
            if (curr_wr_data !== e_next[r]) begin
               n_fail++; $display("FAIL curr_wr_data row=%0d got=%0d exp=%0d", r, curr_wr_data, e_next[r]);
            end
            n_checks++;
            if (prev_wr_data !== c0[r]) begin
               n_fail++; $display("FAIL prev_wr_data row=%0d got=%0d exp=%0d", r, prev_wr_data, c0[r]);
            end
            n_checks++;
            if (sol_u !== c0[r] || sol_uprev !== p0[r]) begin
               n_fail++; $display("FAIL sol_u/uprev row=%0d got=%0d/%0d exp=%0d/%0d", r, sol_u, sol_uprev, c0[r], p0[r]);
            end
            n_checks++;
            if (sol_up !== e_up[r] || sol_down !== e_dn[r]) begin
               n_fail++; $display("FAIL sol_up/down row=%0d got=%0d/%0d exp=%0d/%0d", r, sol_up, sol_down, e_up[r], e_dn[r]);
            end
            n_checks++;
            if (sol_left !== e_l[r] || sol_right !== e_r[r]) begin
               n_fail++; $display("FAIL sol_left/right row=%0d got=%0d/%0d exp=%0d/%0d", r, sol_left, sol_right, e_l[r], e_r[r]);
            end
         end
         start = (cyc == 0) || (cyc == restart_cyc);
         rst   = (cyc == rst_cyc);
         @(negedge clk);
      end
      start = 1'b0;
      rst   = 1'b0;
      n_checks++;
      if (rst_cyc < 0) begin
         if (wr_cnt != N || done_cnt != 1) begin
            n_fail++; $display("FAIL sweep_counts writes=%0d dones=%0d exp=%0d/1", wr_cnt, done_cnt, N);
         end
      end else begin
         if (done_cnt != 0) begin
            n_fail++; $display("FAIL abort_done dones=%0d exp=0", done_cnt);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({busy, done, wr_en} !== 3'b000 || rd_addr !== '0 || wr_addr !== '0) begin
         n_fail++; $display("FAIL reset_ctrl got busy/done/wr=%b rd=%0d wa=%0d exp=000/0/0", {busy, done, wr_en}, rd_addr, wr_addr);
      end
      n_checks++;
      if ({sol_left, sol_right, sol_up, sol_down, sol_u, sol_uprev} !== '0) begin
         n_fail++; $display("FAIL reset_sol got nonzero=%0d exp=0", sol_up | sol_down | sol_left | sol_right | sol_u | sol_uprev);
      end
      n_checks++;
      if (probe_out !== '0) begin
         n_fail++; $display("FAIL reset_probe got=%0d exp=0", probe_out);
      end
      // start coincident with reset must not begin a sweep
      load_directed(1, 10);
      rst = 1'b1;
      start = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || wr_en !== 1'b0) begin
         n_fail++; $display("FAIL start_with_rst got busy=%0b wr_en=%0b exp=0/0", busy, wr_en);
      end
   endtask

   task automatic test_directed();
      load_directed(1, 10);
      run_sweep(-1, -1);
      n_checks++;
      if (curr_mem[0] !== 18'd22 || curr_mem[1] !== 18'd24 || curr_mem[2] !== 18'd26 || curr_mem[3] !== 18'd23) begin
         n_fail++; $display("FAIL directed_curr got=%0d,%0d,%0d,%0d exp=22,24,26,23", curr_mem[0], curr_mem[1], curr_mem[2], curr_mem[3]);
      end
      n_checks++;
      if (prev_mem[0] !== 18'd1 || prev_mem[1] !== 18'd2 || prev_mem[2] !== 18'd3 || prev_mem[3] !== 18'd4) begin
         n_fail++; $display("FAIL directed_prev got=%0d,%0d,%0d,%0d exp=1,2,3,4", prev_mem[0], prev_mem[1], prev_mem[2], prev_mem[3]);
      end
      n_checks++;
      if (probe_out !== 18'd26) begin
         n_fail++; $display("FAIL directed_probe got=%0d exp=26", probe_out);
      end
   endtask

   task automatic test_left_edge();
      load_directed(1, 10);
      is_left_edge = 1'b1;
      run_sweep(-1, -1);
      is_left_edge = 1'b0;
      n_checks++;
      if (curr_mem[0] !== 18'd12 || curr_mem[1] !== 18'd14 || curr_mem[2] !== 18'd16 || curr_mem[3] !== 18'd13) begin
         n_fail++; $display("FAIL left_edge_curr got=%0d,%0d,%0d,%0d exp=12,14,16,13", curr_mem[0], curr_mem[1], curr_mem[2], curr_mem[3]);
      end
   endtask

   task automatic test_probe_zero();
      load_directed(0, 0);
      run_sweep(-1, -1);
      n_checks++;
      if (probe_out !== '0) begin
         n_fail++; $display("FAIL probe_zero got=%0d exp=0", probe_out);
      end
   endtask

   task automatic test_restart_ignored();
      load_directed(1, 10);
      run_sweep(3, -1);
   endtask

   task automatic test_reset_mid_sweep();
      load_directed(1, 10);
      run_sweep(-1, 3);
      run_sweep(-1, -1);
   endtask

   task automatic test_random();
      int rs;
      for (int it = 0; it < 8; it++) begin
         if (it % 2 == 0) begin
            for (int i = 0; i < 8; i++) begin
               init_curr[i] = DW'($urandom);
               init_prev[i] = DW'($urandom);
               left_mem[i]  = DW'($urandom);
               right_mem[i] = DW'($urandom);
            end
            do_load();
         end
         is_left_edge  = 1'($urandom_range(0, 1));
         is_right_edge = 1'($urandom_range(0, 1));
         rs = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, N + 1)) : -1;
         run_sweep(rs, -1);
      end
      is_left_edge  = 1'b0;
      is_right_edge = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin
         init_curr[i] = '0;
         init_prev[i] = '0;
         left_mem[i]  = '0;
         right_mem[i] = '0;
      end
      @(negedge clk);
      test_reset();
      test_directed();
      test_left_edge();
      test_probe_zero();
      test_restart_ignored();
      test_reset_mid_sweep();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/drum_column_sweeper.md
Name: drum_column_sweeper

Overview:
- Sequencer for one drum column; sits between that column's M10K state memories and an external per-node solver.
- On each time step it streams rows 0..N_ROWS-1 out of the u_curr and u_prev RAMs and presents each node's neighbourhood to the solver.
- It takes the solver's combinational u_next result and writes it back in place: curr gets u_next, prev gets the old curr.
- It also captures a probe node for audio output.

Parameters:
- N_ROWS, 32, rows per column (>=3)
- ADDR_W, 5, RAM address width, with 2**ADDR_W >= N_ROWS
- DATA_W, 18, signed node width (1.17 fixed point)
- PROBE_ROW, 16, row whose new value is captured to probe_out

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse that begins a sweep
- is_left_edge  in  1  static; forces the left neighbour to 0
- is_right_edge  in  1  static; forces the right neighbour to 0
- busy  out  1  high while a sweep is in progress
- done  out  1  one-cycle pulse at the end of a sweep
- rd_addr  out  ADDR_W  read address shared by own curr/prev RAMs and broadcast to neighbour columns
- curr_rd_data  in  DATA_W  own u_curr at rd_addr, 1-cycle latency
- prev_rd_data  in  DATA_W  own u_prev at rd_addr, 1-cycle latency
- left_rd_data  in  DATA_W  left column u_curr at rd_addr, 1-cycle latency
- right_rd_data  in  DATA_W  right column u_curr at rd_addr, 1-cycle latency
- wr_en  out  1  write strobe for both own RAMs
- wr_addr  out  ADDR_W  write address
- curr_wr_data  out  DATA_W  value written to u_curr (equals sol_next)
- prev_wr_data  out  DATA_W  value written to u_prev (old u_curr)
- sol_left, sol_right, sol_up, sol_down, sol_u, sol_uprev  out  DATA_W each  neighbourhood presented to the solver
- sol_next  in  DATA_W  solver result, combinational from the sol_* outputs
- probe_out  out  DATA_W  last new value written at PROBE_ROW

Behaviour:
- Reset values: busy=0, done=0, wr_en=0, rd_addr=0, wr_addr=0, all sol_* outputs=0, probe_out=0, FSM=IDLE. Reset mid-sweep aborts the sweep; wr_en is 0 from the next cycle onward.
- FSM states and transitions:
  - IDLE: on start, issue rd_addr=0, set busy=1, go to PRIME.
  - PRIME: latch row 0 data (curr, prev, left, right) into the window, issue rd_addr=1, go to RUN.
  - RUN: one row r per cycle, r=0..N_ROWS-1, on cycles 2..N_ROWS+1 after start.
  - FIN: done=1 for one cycle, busy=0, return to IDLE.
- Window registers: dn (row r-1 curr), cur (row r curr), pv (row r prev), lf and rt (row r left/right). Incoming row r+1 data is the up neighbour.
- RUN cycle for row r:
  - sol_u=cur, sol_uprev=pv, sol_down=dn, sol_up=curr_rd_data.
  - sol_left=lf and sol_right=rt, each forced to 0 when its edge flag is set.
  - Row boundaries: sol_down=0 when r=0; sol_up=0 when r=N_ROWS-1.
  - wr_en=1, wr_addr=r, curr_wr_data=sol_next, prev_wr_data=cur.
  - Window shifts: dn<=cur, cur<=curr_rd_data, pv/lf/rt<=incoming row values.
  - rd_addr=r+2 while r+2<N_ROWS; otherwise no new read is needed and rd_addr holds.
- The sol_* outputs are combinational from the window, so the solver output is consumed in the same cycle it is presented.
- Latency: start at cycle 0; writes on cycles 2..N_ROWS+1; done on cycle N_ROWS+2.
- Hazards:
  - Each row is read 2 cycles before it is written, so own-column RAW hazards cannot occur.
  - All columns must be started on the same cycle. Under lockstep, a neighbour's read of row r (cycle r) precedes this column's write of row r (cycle r+2).
- start while busy is ignored. start coincident with rst: reset wins.
- Probe: when writing r==PROBE_ROW, probe_out<=sol_next on that clock edge. It is held otherwise.
- No arithmetic is done here. Data passes through unmodified, except the boundary zero substitution.

Decomposition:
- Package drum_pkg:
  - DATA_W constant
  - typedef node_t (logic signed [DATA_W-1:0])
  - FSM enum sweep_state_t {IDLE, PRIME, RUN, FIN}
- No sub-module. The solver stays external so one solver instance per column can be wired beside this block.

Test Plan (N_ROWS=4, PROBE_ROW=2, bench solver model sol_next = sol_up+sol_down+sol_left+sol_right):
- Curr rows [1,2,3,4], prev [0,0,0,0], left=right=10 per row, no edge flags; pulse start -> writes at cycles 2..5 with curr_wr_data 22,24,26,23 and prev_wr_data 1,2,3,4; done at cycle 6; busy high on cycles 1..5.
- Same stimulus with is_left_edge=1 -> curr_wr_data 12,14,16,13.
- Read-address trace -> rd_addr 0,1,2,3 on cycles 0..3; never exceeds 3; wr_addr 0,1,2,3 on cycles 2..5.
- probe_out equals 26 after cycle 4, unchanged after done; a second sweep with curr=[0,0,0,0] and left=right=0 -> probe_out=0.
- start re-pulsed at cycle 3 -> ignored; exactly 4 writes; single done at cycle 6.
- rst asserted at cycle 3 -> wr_en=0 from cycle 4; busy=0, no done; a new start then completes a full 4-row sweep.
